uart_frame_parser: RTL and testbench

Command-frame parser between uart_rx and the phase-delay generator. Consumes received bytes (rx_data and rx_int) and assembles 5-byte frames. Checks each frame with an XOR checksum. Valid frames write per-channel delay shadow registers, commit them atomically to s0..s7, or set the run enable. It replaces the direct byte-to-delay mapping with an error-checked, atomic-update protocol.

---
 rtl/uart_frame_parser_if.sv | 8 +
 rtl/uart_frame_parser.sv | 125 ++++++++++++
 tb/tb_uart_frame_parser.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// Received-byte bus from uart_rx into the frame parser.
interface uart_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_int;

  modport master (output rx_data, output rx_int);
  modport slave  (input  rx_data, input  rx_int);
endinterface

// File: rtl/uart_frame_parser.sv
// Command-frame parser: HEADER CMD CH DATA CSUM frames with XOR checksum,
// shadowed per-channel delay registers committed atomically to s0..s7.
module uart_frame_parser #(
  parameter int          TIMEOUT_CYC = 500000,
  parameter logic [7:0]  HEADER      = 8'hAA
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  uart_frame_parser_if.slave   rx,
  output logic [7:0]           s0, s1, s2, s3, s4, s5, s6, s7,
  output logic                 run,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [7:0]           err_cnt
);
  localparam int NUM_CH = 8;
  localparam int TW     = $clog2(TIMEOUT_CYC);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_CH   = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;
  localparam logic [2:0] ST_EXEC = 3'd5;

  localparam logic [7:0] CMD_WR_CH  = 8'h01;
  localparam logic [7:0] CMD_WR_ALL = 8'h02;
  localparam logic [7:0] CMD_COMMIT = 8'h03;
  localparam logic [7:0] CMD_RUN    = 8'h04;

  logic [2:0]    state;
  logic [7:0]    cmd, ch, data;
  logic [TW-1:0] tcnt;
  logic          rx_int_d;
  logic          evt, in_frame, tmo, csum_ok, legal, rej, err_set, exec;

  logic [NUM_CH-1:0][7:0] shadow;
  logic [NUM_CH-1:0][7:0] s_q;

  // A byte is complete on the falling edge of the uart_rx busy flag.
  assign evt      = rx_int_d & ~rx.rx_int;
  assign in_frame = (state == ST_CMD) || (state == ST_CH) ||
                    (state == ST_DATA) || (state == ST_CSUM);
  // A byte arriving on the timeout cycle takes priority over the abort.
  assign tmo      = in_frame && !evt && (tcnt == TW'(TIMEOUT_CYC - 1));
  assign csum_ok  = (rx.rx_data == (cmd ^ ch ^ data));
  assign exec     = (state == ST_EXEC);

  // Legality of the latched command; ch only matters for single-channel writes.
  always_comb begin
    legal = 1'b0;
    case (cmd)
      CMD_WR_CH:                       legal = (ch < 8'(NUM_CH));
      CMD_WR_ALL, CMD_COMMIT, CMD_RUN: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
  end

  assign rej     = (state == ST_CSUM) && evt && !(csum_ok && legal);
  assign err_set = rej | tmo;

  // Edge detector register for rx_int.
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) rx_int_d <= 1'b0;
    else         rx_int_d <= rx.rx_int;

  // Frame FSM and field latches; no resync on HEADER mid-frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      cmd   <= '0;
      ch    <= '0;
      data  <= '0;
    end else if (tmo) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (evt && rx.rx_data == HEADER) state <= ST_CMD;
        ST_CMD:  if (evt) begin cmd  <= rx.rx_data; state <= ST_CH;   end
        ST_CH:   if (evt) begin ch   <= rx.rx_data; state <= ST_DATA; end
        ST_DATA: if (evt) begin data <= rx.rx_data; state <= ST_CSUM; end
        ST_CSUM: if (evt) state <= (csum_ok && legal) ? ST_EXEC : ST_IDLE;
        ST_EXEC: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Inter-byte idle counter, only running while a frame is partially received.
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst)                      tcnt <= '0;
    else if (evt || !in_frame || tmo) tcnt <= '0;
    else                              tcnt <= tcnt + 1'b1;

  // Result pulses and saturating error counter.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
      run       <= 1'b0;
    end else begin
      frame_ok  <= exec;
      frame_err <= err_set;
      if (err_set && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (exec && cmd == CMD_RUN)      run     <= data[0];
    end
  end

  // Per-channel shadow and committed delay registers.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Shadow write by WR_CH (matching channel) or WR_ALL.
    always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) shadow[i] <= '0;
      else if (exec && ((cmd == CMD_WR_CH && ch[2:0] == 3'(i)) || cmd == CMD_WR_ALL))
        shadow[i] <= data;

    // All channels commit on the same edge.
    always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst)                       s_q[i] <= '0;
      else if (exec && cmd == CMD_COMMIT) s_q[i] <= shadow[i];
  end

  assign {s7, s6, s5, s4, s3, s2, s1, s0} = s_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: frame table plus timing corner cases.
module tb_uart_frame_parser;
  localparam int T  = 64;
  localparam int NV = 15;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] s0, s1, s2, s3, s4, s5, s6, s7, err_cnt;
  logic       run, frame_ok, frame_err;
  logic [63:0] spack;

  uart_frame_parser_if bus ();

  uart_frame_parser #(.TIMEOUT_CYC(T), .HEADER(8'hAA)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(bus),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6), .s7(s7),
    .run(run), .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;
  assign spack = {s7, s6, s5, s4, s3, s2, s1, s0};

  int ok_p = 0, err_p = 0, overlap = 0;
  always @(negedge sys_clk) begin
    if (frame_ok)              ok_p++;
    if (frame_err)             err_p++;
    if (frame_ok && frame_err) overlap++;
  end

  typedef struct {
    int          n;
    logic [55:0] b;   // first byte in [55:48]
    int          ok;
    int          err;
    logic [63:0] s;
    logic        run;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl [NV];
  int checks = 0, errors = 0;
  int ok0, e0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Leaves the bench inside the byte's evt cycle.
  task automatic put(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_int  = 1'b1;
    tick(3);
    bus.rx_int  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    put(b);
    tick(6);
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int k = 0; k < 5; k++) send_byte(f[39-8*k -: 8]);
  endtask

  initial begin
    sys_rst     = 1'b1;
    bus.rx_int  = 1'b0;
    bus.rx_data = 8'h00;

    tbl[0]  = '{5, 56'hAA010340420000, 1, 0, 64'h0, 1'b0, 8'd0};
    tbl[1]  = '{5, 56'hAA030000030000, 1, 0, 64'h00000000_40000000, 1'b0, 8'd0};
    tbl[2]  = '{5, 56'hAA010340430000, 0, 1, 64'h00000000_40000000, 1'b0, 8'd1};
    tbl[3]  = '{5, 56'hAA010910180000, 0, 1, 64'h00000000_40000000, 1'b0, 8'd2};
    tbl[4]  = '{5, 56'hAA070000070000, 0, 1, 64'h00000000_40000000, 1'b0, 8'd3};
    tbl[5]  = '{5, 56'hAA000000000000, 0, 1, 64'h00000000_40000000, 1'b0, 8'd4};
    tbl[6]  = '{5, 56'hAA030000030000, 1, 0, 64'h00000000_40000000, 1'b0, 8'd4};
    tbl[7]  = '{5, 56'hAA02007F7D0000, 1, 0, 64'h00000000_40000000, 1'b0, 8'd4};
    tbl[8]  = '{5, 56'hAA030000030000, 1, 0, 64'h7F7F7F7F_7F7F7F7F, 1'b0, 8'd4};
    tbl[9]  = '{5, 56'hAA040001050000, 1, 0, 64'h7F7F7F7F_7F7F7F7F, 1'b1, 8'd4};
    tbl[10] = '{5, 56'hAA040000040000, 1, 0, 64'h7F7F7F7F_7F7F7F7F, 1'b0, 8'd4};
    tbl[11] = '{7, 56'h5512AA01002021, 1, 0, 64'h7F7F7F7F_7F7F7F7F, 1'b0, 8'd4};
    tbl[12] = '{5, 56'hAA030000030000, 1, 0, 64'h7F7F7F7F_7F7F7F20, 1'b0, 8'd4};
    tbl[13] = '{5, 56'hAA010711170000, 1, 0, 64'h7F7F7F7F_7F7F7F20, 1'b0, 8'd4};
    tbl[14] = '{5, 56'hAA030000030000, 1, 0, 64'h117F7F7F_7F7F7F20, 1'b0, 8'd4};

    tick(3);
    sys_rst = 1'b0;
    tick(2);
    chk("reset_s", spack, 64'h0);
    chk("reset_ctl", {run, frame_ok, frame_err, err_cnt}, 11'h0);

    for (int i = 0; i < NV; i++) begin
      ok0 = ok_p; e0 = err_p;
      for (int k = 0; k < tbl[i].n; k++) send_byte(tbl[i].b[55-8*k -: 8]);
      tick(4);
      chk($sformatf("v%0d_ok", i),  64'(ok_p - ok0), 64'(tbl[i].ok));
      chk($sformatf("v%0d_err", i), 64'(err_p - e0), 64'(tbl[i].err));
      chk($sformatf("v%0d_s", i),   spack,   tbl[i].s);
      chk($sformatf("v%0d_run", i), run,     tbl[i].run);
      chk($sformatf("v%0d_ec", i),  err_cnt, tbl[i].ec);
    end

    // Accept latency: frame_ok and run update two cycles after the CSUM byte.
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h00); send_byte(8'h01);
    put(8'h05);
    tick(1);
    chk("lat_ok_n1", frame_ok, 1'b0);
    chk("lat_run_n1", run, 1'b0);
    tick(1);
    chk("lat_ok_n2", frame_ok, 1'b1);
    chk("lat_run_n2", run, 1'b1);
    tick(6);

    // Reject latency: frame_err one cycle after the CSUM byte.
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h00); send_byte(8'h01);
    put(8'h04);
    tick(1);
    chk("rej_err_n1", frame_err, 1'b1);
    chk("rej_ec", err_cnt, 8'd5);
    tick(1);
    chk("rej_err_n2", frame_err, 1'b0);
    tick(6);

    // Timeout after a partial frame.
    send_byte(8'hAA);
    put(8'h01);
    tick(T);
    chk("tmo_early", frame_err, 1'b0);
    tick(1);
    chk("tmo_err", frame_err, 1'b1);
    chk("tmo_ec", err_cnt, 8'd6);
    tick(6);
    ok0 = ok_p; e0 = err_p;
    send_frame(40'hAA01002021);
    tick(4);
    chk("post_tmo_ok", 64'(ok_p - ok0), 64'd1);
    chk("post_tmo_err", 64'(err_p - e0), 64'd0);

    // Byte landing exactly on the timeout cycle wins.
    ok0 = ok_p; e0 = err_p;
    send_byte(8'hAA);
    put(8'h01);
    tick(T - 3);
    bus.rx_data = 8'h00;
    bus.rx_int  = 1'b1;
    tick(3);
    bus.rx_int  = 1'b0;
    tick(6);
    send_byte(8'h20);
    send_byte(8'h21);
    tick(4);
    chk("land_ok", 64'(ok_p - ok0), 64'd1);
    chk("land_err", 64'(err_p - e0), 64'd0);
    chk("land_ec", err_cnt, 8'd6);

    // Asynchronous reset mid-frame.
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_s", spack, 64'h0);
    chk("arst_ctl", {run, frame_ok, frame_err, err_cnt}, 11'h0);
    tick(2);
    sys_rst = 1'b0;
    tick(2);
    ok0 = ok_p; e0 = err_p;
    send_byte(8'h30); send_byte(8'h32);
    tick(4);
    chk("tail_ok", 64'(ok_p - ok0), 64'd0);
    chk("tail_err", 64'(err_p - e0), 64'd0);
    send_frame(40'hAA03000003);
    tick(4);
    chk("resync_ok", 64'(ok_p - ok0), 64'd1);
    chk("resync_s", spack, 64'h0);

    // Saturation of err_cnt.
    e0 = err_p;
    for (int i = 0; i < 300; i++) send_frame(40'hAA010000FF);
    tick(4);
    chk("sat_pulses", 64'(err_p - e0), 64'd300);
    chk("sat_ec", err_cnt, 8'hFF);

    chk("overlap", 64'(overlap), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
